vga_reg_display: RTL and testbench

Parametrised VGA debug display for the pipeline CPU board. It combines the pixel-clock divider, sync/scan timing and a register painter. Instead of one fixed word, it shows NUM_CH live CPU words (e.g. PC, instruction, ALU result) as rows of bit cells. Values are snapshotted once per frame so the image never tears mid-frame.

---
 rtl/vga_reg_display_if.sv | 27 ++
 rtl/vga_reg_display.sv | 139 +++++++++++++
 tb/tb_vga_reg_display.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vga_reg_display_if.sv
// Display-side bundle: live CPU words in, VGA timing/colour and frame marker out.
interface vga_reg_display_if #(
   parameter int NUM_CH  = 4,
   parameter int CH_W    = 16,
   parameter int COLOR_W = 3
);
   logic [NUM_CH*CH_W-1:0] values;
   logic                   hs;
   logic                   vs;
   logic                   de;
   logic [COLOR_W-1:0]     r;
   logic [COLOR_W-1:0]     g;
   logic [COLOR_W-1:0]     b;
   logic [10:0]            x;
   logic [10:0]            y;
   logic                   frame_start;

   modport master (
      input  values,
      output hs, vs, de, r, g, b, x, y, frame_start
   );

   modport slave (
      output values,
      input  hs, vs, de, r, g, b, x, y, frame_start
   );
endinterface

// File: rtl/vga_reg_display.sv
// VGA debug display: pixel divider, sync/scan counters and a painter drawing
// NUM_CH frame-snapshotted words as rows of bit cells (MSB leftmost).
module vga_reg_display #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter int   CLK_DIV  = 2,
   parameter int   NUM_CH   = 4,
   parameter int   CH_W     = 16,
   parameter int   COLOR_W  = 3,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   vga_reg_display_if.master   vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CELL_W  = H_ACTIVE / CH_W;
   localparam int BAND_H  = V_ACTIVE / NUM_CH;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   // Sync window bounds are 12 bits so an end of exactly 2048 still compares correctly.
   localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0]       r_div;
   logic                   w_pix_en;
   logic [10:0]            r_h;
   logic [10:0]            r_v;
   logic                   w_h_wrap;
   logic                   w_v_wrap;
   logic [NUM_CH*CH_W-1:0] r_shadow;

   logic                   w_active;
   logic                   w_hs_raw;
   logic                   w_vs_raw;
   logic [10:0]            w_cell;
   logic [10:0]            w_band;
   logic [10:0]            w_cell_off;
   logic [10:0]            w_band_off;
   logic [CH_W-1:0]        w_word;
   logic                   w_bit;
   logic [COLOR_W-1:0]     w_r;
   logic [COLOR_W-1:0]     w_g;
   logic [COLOR_W-1:0]     w_b;

   assign w_pix_en = (r_div == DIV_W'(CLK_DIV - 1));
   assign w_h_wrap = (r_h == 11'(H_TOTAL - 1));
   assign w_v_wrap = (r_v == 11'(V_TOTAL - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_div <= '0;
      else if (w_pix_en) r_div <= '0;
      else               r_div <= r_div + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h <= '0;
         r_v <= '0;
      end else if (w_pix_en) begin
         if (w_h_wrap) begin
            r_h <= '0;
            r_v <= w_v_wrap ? 11'd0 : r_v + 11'd1;
         end else begin
            r_h <= r_h + 11'd1;
         end
      end
   end

   // Words are captured only at the frame wrap so a frame never mixes two values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  r_shadow <= '0;
      else if (w_pix_en && w_h_wrap && w_v_wrap) r_shadow <= vga.values;
   end

   assign w_active   = (r_h < 11'(H_ACTIVE)) && (r_v < 11'(V_ACTIVE));
   assign w_cell     = r_h / 11'(CELL_W);
   assign w_band     = r_v / 11'(BAND_H);
   assign w_cell_off = r_h % 11'(CELL_W);
   assign w_band_off = r_v % 11'(BAND_H);
   assign w_hs_raw   = ({1'b0, r_h} >= HS_START && {1'b0, r_h} < HS_END) ? HS_POL : ~HS_POL;
   assign w_vs_raw   = ({1'b0, r_v} >= VS_START && {1'b0, r_v} < VS_END) ? VS_POL : ~VS_POL;

   always_comb begin
      w_word = '0;
      w_bit  = 1'b0;
      w_r    = '0;
      w_g    = '0;
      w_b    = '0;
      if (w_active && w_cell < 11'(CH_W) && w_band < 11'(NUM_CH)) begin
         for (int k = 0; k < NUM_CH; k++)
            if (w_band == 11'(k)) w_word = r_shadow[k*CH_W +: CH_W];
         for (int c = 0; c < CH_W; c++)
            if (w_cell == 11'(c)) w_bit = w_word[CH_W-1-c];
         if (w_cell_off != 11'd0 && w_band_off != 11'd0) begin
            if (w_bit) w_g = '1;
            else       w_r = COLOR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga.hs <= ~HS_POL;
         vga.vs <= ~VS_POL;
         vga.de <= 1'b0;
         vga.r  <= '0;
         vga.g  <= '0;
         vga.b  <= '0;
         vga.x  <= '0;
         vga.y  <= '0;
      end else if (w_pix_en) begin
         vga.hs <= w_hs_raw;
         vga.vs <= w_vs_raw;
         vga.de <= w_active;
         vga.r  <= w_r;
         vga.g  <= w_g;
         vga.b  <= w_b;
         vga.x  <= r_h;
         vga.y  <= r_v;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vga.frame_start <= 1'b0;
      else     vga.frame_start <= w_pix_en && w_h_wrap && w_v_wrap;
   end

endmodule

// File: tb/tb_vga_reg_display.sv
// Randomised check of vga_reg_display on a small geometry against a model that
// derives every pixel from the clock count since reset release.
module tb_vga_reg_display;

   localparam int   HA = 18, HFP = 2, HSY = 3, HBP = 2;
   localparam int   VA = 9,  VFP = 1, VSY = 2, VBP = 1;
   localparam int   DIV = 2, NCH = 2, CW = 4, COLW = 3;
   localparam logic HP = 1'b0, VP = 1'b1;
   localparam int   HT = HA + HFP + HSY + HBP;
   localparam int   VT = VA + VFP + VSY + VBP;
   localparam int   FRAME = HT * VT;
   localparam int   CELLW = HA / CW;
   localparam int   BANDH = VA / NCH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NCH*CW-1:0] vals = '0;

   always #5 clk = ~clk;

   vga_reg_display_if #(.NUM_CH(NCH), .CH_W(CW), .COLOR_W(COLW)) vif ();
   assign vif.values = vals;

   vga_reg_display #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .CLK_DIV(DIV), .NUM_CH(NCH), .CH_W(CW), .COLOR_W(COLW),
      .HS_POL(HP), .VS_POL(VP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .vga (vif)
   );

   int n_chk  = 0;
   int n_pass = 0;

   int            t;
   logic [CW-1:0] m_sh [NCH];
   logic          e_hs, e_vs, e_de, e_fs;
   logic [8:0]    e_rgb;
   int            e_x, e_y;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      t = 0;
      for (int k = 0; k < NCH; k++) m_sh[k] = '0;
      e_hs = ~HP; e_vs = ~VP; e_de = 1'b0; e_fs = 1'b0;
      e_rgb = '0; e_x = 0; e_y = 0;
   endtask

   function automatic logic [8:0] paint(int px, int py);
      int c, k;
      logic [CW-1:0] w;
      if (px >= HA || py >= VA) return 9'b0;
      c = px / CELLW;
      k = py / BANDH;
      if (c >= CW || k >= NCH) return 9'b0;
      if (px % CELLW == 0 || py % BANDH == 0) return 9'b0;
      w = m_sh[k];
      if (w[CW-1-c]) return {3'b000, 3'b111, 3'b000};
      return {3'b001, 3'b000, 3'b000};
   endfunction

   // Called right after each rising edge; output pixel m shows scan position m-1.
   task automatic model_edge();
      int m, q;
      t++;
      e_fs = 1'b0;
      if (t % DIV == 0) begin
         m = t / DIV;
         q = (m - 1) % FRAME;
         e_x = q % HT;
         e_y = q / HT;
         e_de = (e_x < HA) && (e_y < VA);
         e_hs = (e_x >= HA + HFP && e_x < HA + HFP + HSY) ? HP : ~HP;
         e_vs = (e_y >= VA + VFP && e_y < VA + VFP + VSY) ? VP : ~VP;
         e_rgb = paint(e_x, e_y);
         if (m % FRAME == 0) begin
            e_fs = 1'b1;
            for (int k = 0; k < NCH; k++) m_sh[k] = vals[k*CW +: CW];
         end
      end
   endtask

   task automatic check_all(input string pfx);
      check({pfx, ".hs"},  32'(vif.hs), 32'(e_hs));
      check({pfx, ".vs"},  32'(vif.vs), 32'(e_vs));
      check({pfx, ".de"},  32'(vif.de), 32'(e_de));
      check({pfx, ".rgb"}, 32'({vif.r, vif.g, vif.b}), 32'(e_rgb));
      check({pfx, ".x"},   32'(vif.x), 32'(e_x));
      check({pfx, ".y"},   32'(vif.y), 32'(e_y));
      check({pfx, ".fs"},  32'(vif.frame_start), 32'(e_fs));
   endtask

   task automatic step(input string pfx);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(pfx);
      if ($urandom_range(0, 39) == 0) vals = (NCH*CW)'($urandom);
   endtask

   initial begin
      model_reset();
      vals = (NCH*CW)'($urandom);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check_all("reset");
      end
      rst = 1'b0;

      for (int i = 0; i < 3 * FRAME * DIV + 40; i++) step("run");

      for (int i = 0; i < FRAME * DIV && e_y != 5; i++) step("seek");
      check("reach_y5", 32'(vif.y), 32'd5);

      vals = '1;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("midrst");
      repeat (3) begin
         @(negedge clk);
         check_all("midrst_hold");
      end
      rst = 1'b0;

      for (int i = 0; i < 2 * FRAME * DIV + 20; i++) step("after");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
